// File: rtl/serial_sub16.sv
// rtl/serial_sub16.sv - bit-serial two's-complement subtractor with status flags
// Optional add/subtract select: define SERIAL_SUB16_ADD_MODE_EN to add the op port.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_SUB16_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             borrow,
  output logic             parity,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] y_sh_q, y_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             borrow_q, borrow_d;
  logic             parity_q, parity_d;
  logic             overflow_q, overflow_d;

  // load_sub selects the operation being accepted; run_sub the one in flight
  logic load_sub;
  logic run_sub;
`ifdef SERIAL_SUB16_ADD_MODE_EN
  logic op_q, op_d;
  assign load_sub = op;
  assign run_sub  = op_q;
`else
  assign load_sub = 1'b1;
  assign run_sub  = 1'b1;
`endif

  logic             s_bit;
  logic             c_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  assign s_bit    = x_sh_q[0] ^ y_sh_q[0] ^ c_q;
  assign c_nxt    = (x_sh_q[0] & y_sh_q[0]) | (x_sh_q[0] & c_q) | (y_sh_q[0] & c_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_full = {s_bit, r_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    x_sh_d     = x_sh_q;
    y_sh_d     = y_sh_q;
    r_sh_d     = r_sh_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    x_msb_d    = x_msb_q;
    y_msb_d    = y_msb_q;
    busy_d     = busy_q;
    done_d     = done_q;
    z_d        = z_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    borrow_d   = borrow_q;
    parity_d   = parity_q;
    overflow_d = overflow_q;
`ifdef SERIAL_SUB16_ADD_MODE_EN
    op_d       = op_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          x_sh_d  = x;
          y_sh_d  = load_sub ? ~y : y;
          c_d     = load_sub;
          cnt_d   = '0;
          x_msb_d = x[WIDTH-1];
          y_msb_d = y[WIDTH-1];
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef SERIAL_SUB16_ADD_MODE_EN
          op_d    = op;
`endif
        end
      end

      RUN: begin
        x_sh_d = x_sh_q >> 1;
        y_sh_d = y_sh_q >> 1;
        r_sh_d = res_full;
        c_d    = c_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          z_d      = res_full;
          sign_d   = res_full[WIDTH-1];
          zero_d   = (res_full == '0);
          parity_d = ~^res_full;
          borrow_d = run_sub ? ~c_nxt : c_nxt;
          // Subtraction overflows only for differing operand signs, addition only for equal ones
          if (run_sub) begin
            overflow_d = (x_msb_q != y_msb_q) && (res_full[WIDTH-1] != x_msb_q);
          end else begin
            overflow_d = (x_msb_q == y_msb_q) && (res_full[WIDTH-1] != x_msb_q);
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      r_sh_q     <= '0;
      c_q        <= 1'b0;
      cnt_q      <= '0;
      x_msb_q    <= 1'b0;
      y_msb_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      z_q        <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      borrow_q   <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_SUB16_ADD_MODE_EN
      op_q       <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      r_sh_q     <= r_sh_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      x_msb_q    <= x_msb_d;
      y_msb_q    <= y_msb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      z_q        <= z_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      borrow_q   <= borrow_d;
      parity_q   <= parity_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_SUB16_ADD_MODE_EN
      op_q       <= op_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign borrow   = borrow_q;
  assign parity   = parity_q;
  assign overflow = overflow_q;

endmodule
